// File: rtl/spi_reg_ctrl.sv
// SPI target (mode 0, 16-bit frames) that writes the PWM configuration register bank from synchronised pins.
// Optional register readback on cipo is enabled by defining SPI_REG_CTRL_READBACK_EN.
module spi_reg_ctrl #(
    parameter int NUM_REGS    = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic       cipo,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       txn_done,
    output logic       txn_err
);

    // state   | meaning
    // IDLE    | waiting for a synchronised ncs falling edge
    // SHIFT   | capturing copi on each synchronised sclk rise
    // COMMIT  | one clk: apply write, pulse done/err
    // WAIT_CS | frame finished, ignore sclk until ncs high
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        COMMIT  = 2'd2,
        WAIT_CS = 2'd3
    } state_t;

    localparam int NREG_ARR = (NUM_REGS > 5) ? NUM_REGS : 5;

    state_t                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [15:0]            shift_q, shift_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   wr_en;
    logic [7:0]             regs_q [NREG_ARR];

    logic [SYNC_STAGES-1:0] sclk_sync_q, copi_sync_q, ncs_sync_q;
    logic                   sclk_prev_q, ncs_prev_q;
    logic                   sclk_s, copi_s, ncs_s;
    logic                   sclk_rise, ncs_fall;
    logic                   addr_ok;

    // ncs synchroniser resets low so a frame still in flight at reset release never looks like a new start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            copi_sync_q <= '0;
            ncs_sync_q  <= '0;
            sclk_prev_q <= 1'b0;
            ncs_prev_q  <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi};
            ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], ncs};
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
            ncs_prev_q  <= ncs_sync_q[SYNC_STAGES-1];
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign copi_s    = copi_sync_q[SYNC_STAGES-1];
    assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign ncs_fall  = ~ncs_s & ncs_prev_q;
    assign addr_ok   = (shift_q[14:8] < 7'(NUM_REGS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        wr_en   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ncs_fall) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                // ncs release takes priority over a coincident sclk rise
                if (ncs_s) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (sclk_rise) begin
                    shift_d = {shift_q[14:0], copi_s};
                    if (cnt_q == 4'd15) begin
                        state_d = COMMIT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            COMMIT: begin
                state_d = WAIT_CS;
                if (shift_q[15]) begin
                    if (addr_ok) begin
                        wr_en  = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
`ifdef SPI_REG_CTRL_READBACK_EN
                    if (addr_ok) done_d = 1'b1;
                    else         err_d  = 1'b1;
`else
                    done_d = 1'b1;
`endif
                end
            end
            WAIT_CS: begin
                if (ncs_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG_ARR; i++) regs_q[i] <= '0;
        end else begin
            for (int i = 0; i < NREG_ARR; i++) begin
                if (wr_en && (shift_q[14:8] == 7'(i))) regs_q[i] <= shift_q[7:0];
            end
        end
    end

`ifdef SPI_REG_CTRL_READBACK_EN
    logic       sclk_fall;
    logic [6:0] rd_addr;
    logic [7:0] rd_lookup;
    logic [7:0] rd_q, rd_d;
    logic       cipo_q, cipo_d;

    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign rd_addr   = {shift_q[5:0], copi_s};

    // Entries at or above NUM_REGS are never written, so out-of-range reads return 0x00.
    always_comb begin
        rd_lookup = '0;
        for (int i = 0; i < NREG_ARR; i++) begin
            if (rd_addr == 7'(i)) rd_lookup = regs_q[i];
        end
    end

    always_comb begin
        rd_d   = rd_q;
        cipo_d = cipo_q;
        if (state_q == SHIFT && !ncs_s && sclk_rise && cnt_q == 4'd7) begin
            rd_d = shift_q[6] ? 8'h00 : rd_lookup;
        end
        if (state_q != SHIFT) begin
            cipo_d = 1'b0;
        end else if (sclk_fall && cnt_q >= 4'd8) begin
            cipo_d = rd_q[3'(4'd15 - cnt_q)];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q   <= '0;
            cipo_q <= 1'b0;
        end else begin
            rd_q   <= rd_d;
            cipo_q <= cipo_d;
        end
    end

    assign cipo = cipo_q;
`else
    assign cipo = 1'b0;
`endif

    assign en_reg_out_7_0  = regs_q[0];
    assign en_reg_out_15_8 = regs_q[1];
    assign en_reg_pwm_7_0  = regs_q[2];
    assign en_reg_pwm_15_8 = regs_q[3];
    assign pwm_duty_cycle  = regs_q[4];
    assign txn_done        = done_q;
    assign txn_err         = err_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed-vector bench for spi_reg_ctrl: frame table plus latency, mid-frame reset and readback sequences.
module tb_spi_reg_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, sclk, copi, ncs;
    logic       cipo, txn_done, txn_err;
    logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;

    spi_reg_ctrl #(.NUM_REGS(5), .SYNC_STAGES(2)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .sclk            (sclk),
        .copi            (copi),
        .ncs             (ncs),
        .cipo            (cipo),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .txn_done        (txn_done),
        .txn_err         (txn_err)
    );

    always #5 clk = ~clk;

    int         cyc = 0;
    int         done_cnt = 0, err_cnt = 0, both_cnt = 0, cipo_hi_cnt = 0, done_cyc = 0;
    logic [7:0] pwm70_prev = '0, done_pwm70_now = '0, done_pwm70_prev = '0;
    int         n_vec = 0, n_err = 0, t_last = 0;
    logic [7:0] rd_bits;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (txn_done) begin
            done_cnt++;
            done_cyc        = cyc;
            done_pwm70_now  = en_reg_pwm_7_0;
            done_pwm70_prev = pwm70_prev;
        end
        if (txn_err) err_cnt++;
        if (txn_done && txn_err) both_cnt++;
        if (cipo) cipo_hi_cnt++;
        pwm70_prev = en_reg_pwm_7_0;
    end

    typedef struct {
        logic [15:0] frame;
        int          nrise;
        logic [39:0] exp_regs;
        int          exp_done;
        int          exp_err;
    } vec_t;

    vec_t vecs[10];

    function automatic logic [39:0] regs_bus();
        return {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0, en_reg_out_15_8, en_reg_out_7_0};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic shift_bits(input logic [15:0] f, input int first, input int count);
        for (int i = first; i < first + count; i++) begin
            copi = (i < 16) ? f[15-i] : 1'b0;
            wait_clk(2);
            if (i >= 8 && i < 16) rd_bits[15-i] = cipo;
            sclk = 1'b1;
            if (i == 15) t_last = cyc;
            wait_clk(4);
            sclk = 1'b0;
            wait_clk(2);
        end
    endtask

    task automatic frame(input logic [15:0] f, input int nrise);
        ncs = 1'b0;
        wait_clk(4);
        shift_bits(f, 0, nrise);
        wait_clk(4);
        ncs = 1'b1;
        wait_clk(8);
    endtask

    initial begin
        int d0, e0;
        rst_n = 1'b0; sclk = 1'b0; copi = 1'b0; ncs = 1'b1;

        vecs[0] = '{16'h80F0, 16, 40'h00_00_00_00_F0, 1, 0};
        vecs[1] = '{16'h8580, 16, 40'h00_00_00_00_F0, 0, 1};
        vecs[2] = '{16'h8480, 10, 40'h00_00_00_00_F0, 0, 1};
        vecs[3] = '{16'h8480, 16, 40'h80_00_00_00_F0, 1, 0};
        vecs[4] = '{16'h0155, 16, 40'h80_00_00_00_F0, 1, 0};
        vecs[5] = '{16'h8133, 20, 40'h80_00_00_33_F0, 1, 0};
        vecs[6] = '{16'h83C3, 16, 40'h80_C3_00_33_F0, 1, 0};
        vecs[7] = '{16'hFF11, 16, 40'h80_C3_00_33_F0, 0, 1};
        vecs[8] = '{16'h8055, 16, 40'h80_C3_00_33_55, 1, 0};
        vecs[9] = '{16'h0000, 16, 40'h80_C3_00_33_55, 1, 0};

        wait_clk(4);
        check("reset_regs", 64'(regs_bus()), 64'h0);
        check("reset_outs", 64'({txn_done, txn_err, cipo}), 64'h0);
        rst_n = 1'b1;
        wait_clk(6);

        for (int v = 0; v < 10; v++) begin
            d0 = done_cnt;
            e0 = err_cnt;
            frame(vecs[v].frame, vecs[v].nrise);
            check($sformatf("vec%0d_regs", v), 64'(regs_bus()), 64'(vecs[v].exp_regs));
            check($sformatf("vec%0d_done", v), 64'(done_cnt - d0), 64'(vecs[v].exp_done));
            check($sformatf("vec%0d_err", v), 64'(err_cnt - e0), 64'(vecs[v].exp_err));
        end

        // write latency: register and done pulse appear together, 4 clks after the last sclk pin rise
        frame(16'h82AA, 16);
        check("lat_cycles", 64'(done_cyc - t_last), 64'd4);
        check("lat_val_now", 64'(done_pwm70_now), 64'hAA);
        check("lat_val_prev", 64'(done_pwm70_prev), 64'h00);
        check("lat_regs", 64'(regs_bus()), 64'h80_C3_AA_33_55);

        // reset in the middle of a frame, released with ncs still low
        d0 = done_cnt;
        e0 = err_cnt;
        ncs = 1'b0;
        wait_clk(4);
        shift_bits(16'h82FF, 0, 12);
        rst_n = 1'b0;
        wait_clk(3);
        check("midrst_regs_in_rst", 64'(regs_bus()), 64'h0);
        rst_n = 1'b1;
        wait_clk(3);
        shift_bits(16'h82FF, 12, 4);
        wait_clk(4);
        ncs = 1'b1;
        wait_clk(8);
        check("midrst_regs_after", 64'(regs_bus()), 64'h0);
        check("midrst_pulses", 64'((done_cnt - d0) + (err_cnt - e0)), 64'd0);
        d0 = done_cnt;
        frame(16'h82FF, 16);
        check("midrst_next_frame", 64'(en_reg_pwm_7_0), 64'hFF);
        check("midrst_next_done", 64'(done_cnt - d0), 64'd1);

        frame(16'h84A5, 16);
        check("rb_write", 64'(pwm_duty_cycle), 64'hA5);
        rd_bits = 8'h5A;
        frame(16'h0400, 16);
`ifdef SPI_REG_CTRL_READBACK_EN
        check("rb_cipo_bits", 64'(rd_bits), 64'hA5);
`else
        check("rb_cipo_bits", 64'(rd_bits), 64'h00);
        check("cipo_never_high", 64'(cipo_hi_cnt), 64'd0);
`endif
        check("done_err_overlap", 64'(both_cnt), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
